// File: rtl/display_pkg.sv
// Shared constants for the multiplexed BCD display scanner: segment patterns
// ({g,f,e,d,c,b,a}, active-low) and FSM state encodings.
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner for the timer's BCD digits, with snapshot register.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
//
//   state   | meaning
//   ST_GAP  | one dead cycle at slot start, display dark (anti-ghosting)
//   ST_SHOW | digit idx driven until the prescaler tick
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    snap_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    bcd_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [3:0]            snap_q [NUM_DIGITS];
  logic [3:0]            cur_digit;
  logic [6:0]            seg_dec;
  logic                  blank;
  logic                  any_err;
  logic [NUM_DIGITS-1:0] an_dec;

  assign tick = (div_cnt == DIV_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!clear_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= ST_GAP;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_GAP: state_nxt = ST_SHOW;
      ST_SHOW: begin
        if (tick) begin
          state_nxt = ST_GAP;
          idx_nxt   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
      end
      default: state_nxt = ST_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int j = 0; j < NUM_DIGITS; j++) snap_q[j] <= '0;
    end else if (snap_en) begin
      for (int j = 0; j < NUM_DIGITS; j++) snap_q[j] <= digits_bcd[4*j +: 4];
    end
  end

  assign cur_digit = snap_q[idx];

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_n (seg_dec)
  );

  always_comb begin
    any_err = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (snap_q[j] > 4'd9) any_err = 1'b1;
  end

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx) && snap_q[j] != 4'd0) blank = 1'b0;
`endif
  end

  always_comb begin
    an_dec      = '1;
    an_dec[idx] = 1'b0;
  end

  // idx only changes on the SHOW->GAP edge, so the current idx is the one shown next.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      seg_n   <= SEG_OFF;
      an_n    <= '1;
      bcd_err <= 1'b0;
    end else begin
      bcd_err <= any_err;
      if (state_nxt == ST_SHOW && !blank) begin
        seg_n <= seg_dec;
        an_n  <= an_dec;
      end else begin
        seg_n <= SEG_OFF;
        an_n  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a slot/time model predicts every output cycle.
module tb_bcd_display_scanner;

  localparam int ND = 2;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic [4*ND-1:0] digits_bcd = '0;
  logic          snap_en = 1'b0;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          bcd_err;

  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(R)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .digits_bcd (digits_bcd),
    .snap_en    (snap_en),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [3:0] snap_m [ND];
  int         t_m = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("seg_n", {1'b0, seg_n}, {1'b0, e.seg});
      check("an_n", 8'(an_n), 8'(e.an));
      check("bcd_err", {7'b0, bcd_err}, {7'b0, e.err});
    end
  end

  // Model: cycles since reset give slot and position; slot position 0 is the gap cycle.
  task automatic step(input logic c, input logic [4*ND-1:0] d, input logic s);
    exp_t e;
    int pos, id;
    logic blk;
    logic [ND-1:0] one;
    clear_n = c; digits_bcd = d; snap_en = s;
    e.seg = 7'h7F; e.an = '1; e.err = 1'b0;
    if (!c) begin
      for (int j = 0; j < ND; j++) snap_m[j] = 4'd0;
      t_m = 0;
    end else begin
      t_m++;
      pos = t_m % R;
      id  = (t_m / R) % ND;
      blk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (id > 0) begin
        blk = 1'b1;
        for (int j = id; j < ND; j++) if (snap_m[j] != 4'd0) blk = 1'b0;
      end
`endif
      for (int j = 0; j < ND; j++) if (snap_m[j] > 4'd9) e.err = 1'b1;
      if (pos != 0 && !blk) begin
        one   = 1;
        e.seg = seg_lut[snap_m[id]];
        e.an  = ~(one << id);
      end
      if (s) for (int j = 0; j < ND; j++) snap_m[j] = d[4*j +: 4];
    end
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  function automatic logic [4*ND-1:0] rand_digits();
    logic [4*ND-1:0] d;
    for (int j = 0; j < ND; j++) d[4*j +: 4] = 4'($urandom_range(0, 11));
    if ($urandom_range(0, 3) == 0) d[4*ND-1 -: 4] = 4'd0;
    return d;
  endfunction

  initial begin
    int guard;
    // Reset held with random inputs
    for (int k = 0; k < 3; k++) step(1'b0, rand_digits(), 1'($urandom_range(0, 1)));
    // Steady scan of 42
    for (int k = 0; k < 16; k++) step(1'b1, 8'h42, 1'b1);
    // Snapshot hold
    step(1'b1, 8'h59, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 8'h60, 1'b0);
    // Invalid BCD then recovery
    for (int k = 0; k < 10; k++) step(1'b1, 8'hA3, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 8'h33, 1'b1);
    // Leading zero value
    for (int k = 0; k < 16; k++) step(1'b1, 8'h07, 1'b1);
    // snap_en pulsed only on tick edges
    for (int k = 0; k < 24; k++) step(1'b1, rand_digits(), 1'((t_m + 1) % R == 0));
    // Clear dropped mid-SHOW
    guard = 0;
    while (t_m % R != 2 && guard < 10) begin
      step(1'b1, 8'h18, 1'b1);
      guard++;
    end
    if (t_m % R != 2) begin
      n_tests++; n_fail++;
      $display("FAIL mid_show_sync: pos %0d required 2", t_m % R);
    end
    step(1'b0, 8'h18, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 8'h18, 1'b0);
    // Random traffic with occasional clears
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 39) != 0), rand_digits(), ($urandom_range(0, 3) == 0));
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
